// File: rtl/quad_enc_frontend.sv
// Rotary encoder front end: per-pin synchroniser and debounce, then a quadrature
// decoder driving a saturating or wrapping level register.
module quad_enc_frontend #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit SATURATE        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             primed
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] VMAX    = '1;
  localparam logic [0:0]      ST_PRIME = 1'b0;
  localparam logic [0:0]      ST_RUN   = 1'b1;

  // Bit 1 carries pin A, bit 0 pin B, so each pair reads as {A,B}.
  logic [1:0]       s1_q, s1_d, s2_q, s2_d;
  logic [1:0]       db_q, db_d;
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [0:0]       state_q, state_d;
  logic [1:0]       pcnt_q, pcnt_d;
  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic             up;
  logic [WIDTH:0]   nxt;

  // Gray-code up sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic is_up(input logic [1:0] p, input logic [1:0] c);
    case (p)
      2'b00:   is_up = (c == 2'b01);
      2'b01:   is_up = (c == 2'b11);
      2'b11:   is_up = (c == 2'b10);
      default: is_up = (c == 2'b00);
    endcase
  endfunction

  // Returns {changed, new_value}; a clamped count reports changed = 0.
  function automatic logic [WIDTH:0] count_next(input logic [WIDTH-1:0] v, input logic inc);
    if (inc) begin
      if (SATURATE && (v == VMAX)) return {1'b0, v};
      return {1'b1, v + WIDTH'(1)};
    end
    if (SATURATE && (v == '0)) return {1'b0, v};
    return {1'b1, v - WIDTH'(1)};
  endfunction

  assign up  = is_up(prev_q, db_q);
  assign nxt = count_next(value_q, up);

  always_comb begin
    s1_d    = {enc_a, enc_b};
    s2_d    = s1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    pcnt_d  = pcnt_q;
    prev_d  = prev_q;
    value_d = value_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_q;

    // Debounce stage: accept a level only after DEBOUNCE_CYCLES mismatching cycles.
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    // Decode stage: PRIME adopts the synchronised pins so a held level never counts.
    if (state_q == ST_PRIME) begin
      if (pcnt_q == 2'd2) begin
        db_d    = s2_q;
        cnt_d   = '{default: '0};
        prev_d  = s2_q;
        state_d = ST_RUN;
      end else begin
        pcnt_d = pcnt_q + 2'd1;
      end
    end else begin
      prev_d = db_q;
      if ((prev_q ^ db_q) == 2'b11) begin
        err_d = 1'b1;
      end else if (prev_q != db_q) begin
        dir_d = up;
        if (nxt[WIDTH]) begin
          value_d = nxt[WIDTH-1:0];
          step_d  = 1'b1;
        end
      end
    end

    if (load_en) begin
      value_d = load_value;
      step_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      cnt_q   <= '{default: '0};
      state_q <= ST_PRIME;
      pcnt_q  <= '0;
      prev_q  <= '0;
      value_q <= '0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      prev_q  <= prev_d;
      value_q <= value_d;
      step_q  <= step_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
    end
  end

  assign value  = value_q;
  assign step   = step_q;
  assign err    = err_q;
  assign dir    = dir_q;
  assign primed = (state_q == ST_RUN);

endmodule

// File: doc/quad_enc_frontend.md
Name: quad_enc_frontend

Overview:
- Conditions one mechanical rotary encoder channel pair before it reaches the RGB mixer.
- Per pin: 2-flop synchroniser and stability debounce. Then a quadrature decoder drives a saturating/wrapping level register.
- Three instances sit between io_in[8..13] and the mixer in the user-project wrapper.
- Each instance's value output is a PWM duty level for one colour channel.

Parameters:
WIDTH, 8, bit width of value/load_value.
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required before a pin level is accepted; legal range 1..65535.
SATURATE, 1, 1 = value clamps at 0 and 2^WIDTH-1; 0 = value wraps modulo 2^WIDTH.

Ports:
clk  input  1  system clock (wb_clk_i)
reset  input  1  synchronous, active-low reset
enc_a  input  1  raw encoder pin A, asynchronous
enc_b  input  1  raw encoder pin B, asynchronous
load_en  input  1  synchronous preset strobe
load_value  input  WIDTH  preset value
value  output  WIDTH  current level
step  output  1  one-cycle pulse on each accepted count change
dir  output  1  direction of last legal transition, 1 = up
err  output  1  one-cycle pulse on an illegal double-bit transition
primed  output  1  high once decoder is in RUN

Behaviour:
- Reset: sampled on rising clk while reset==0; all state cleared regardless of other inputs.
  - value=0, step=0, dir=0, err=0, primed=0.
  - Synchroniser flops, debounced levels and debounce counters = 0.
  - FSM = PRIME.
- Synchroniser: two flops per pin; sync output lags pin by 2 edges.
- Debounce, per pin:
  - Counter counts consecutive cycles where sync != debounced level.
  - Counter clears on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level takes the sync value on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never propagates.
  - Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
- FSM PRIME:
  - Counts 3 cycles after reset release.
  - On the 3rd edge, debounced A/B are loaded directly from the sync outputs (no debounce), prev_state is set to {A,B}, FSM moves to RUN, and primed goes 1.
  - No step/err is generated in PRIME.
  - load_en is honoured in PRIME.
- FSM RUN, each cycle:
  - Compare prev_state {A,B} with the current debounced {A,B}, then set prev_state = current.
  - Up sequence: 00->01->11->10->00.
  - Down sequence: reverse.
  - Legal up transition: count +1, step=1, dir=1.
  - Legal down transition: count -1, step=1, dir=0.
  - Both bits changed in the same cycle: err=1, step=0, value and dir unchanged.
  - No change: step=0, err=0.
- Latency: a clean pin edge sampled at edge N gives the debounced change at N+1+DEBOUNCE_CYCLES. value/step/dir update at edge N+2+DEBOUNCE_CYCLES.
- Arithmetic with SATURATE=1:
  - Increment at all-ones leaves value unchanged, step=0.
  - Decrement at 0 leaves value unchanged, step=0.
  - dir still updates on a legal transition.
- Arithmetic with SATURATE=0: wraps (all-ones+1 -> 0, 0-1 -> all-ones), step=1.
- load_en:
  - value=load_value next edge.
  - Overrides any same-cycle step; step=0 that cycle.
  - prev_state still updates.
  - dir and err are computed normally.
- Reset mid-operation: everything returns to reset values and PRIME is re-run. The pin level present afterwards never causes a spurious count.
- step and err are never both 1.

Test Plan:
1. Reset with pins held 11, DEBOUNCE_CYCLES=4 -> primed rises on 3rd edge after reset release; value=0; no step, no err.
2. Four clean up transitions (00->01->11->10->00), each held 10 cycles -> value=4, four step pulses each with dir=1. Each pulse arrives exactly DEBOUNCE_CYCLES+2 edges after the sampled pin edge. Then two down transitions -> value=2, dir=0.
3. 3-cycle glitch on enc_a with DEBOUNCE_CYCLES=4 -> no step, no err, value unchanged. A 4-cycle hold is accepted.
4. SATURATE=1, load 254 then 3 up steps -> value 255, 255, 255; step pulses 1, 0, 0. SATURATE=0 with the same stimulus -> 255, 0, 1.
5. Both pins toggled on the same clock (00->11) -> single err pulse; value and dir unchanged. Next legal transition from 11 counts correctly.
6. Reset driven low mid-debounce with value=37 -> next edge value=0, primed=0. Re-prime completes without counting. load_en coinciding with an up step while value=9 and load_value=100 -> value=100, step=0.
